// File: rtl/pipeline_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pipeline_sequencer: 5-stage pipeline control (stall/flush/PC select,   |
// | boot vector load, interrupt drain/save/jump).        Revision: 1.0     |
// +------------------------------------------------------------------------+
module pipeline_sequencer #(
   parameter int unsigned BOOT_CYCLES  = 2,
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned SAVE_CYCLES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hz_stall,
   input  logic       branch_taken,
   input  logic       irq,
   output logic       pc_en,
   output logic [1:0] pc_sel,
   output logic       ifid_en,
   output logic       idex_en,
   output logic       ifid_flush,
   output logic       idex_flush,
   output logic       exmem_flush,
   output logic       int_push,
   output logic       busy,
   output logic [2:0] state
);

   localparam int unsigned MAX_AB  = (BOOT_CYCLES > DRAIN_CYCLES) ? BOOT_CYCLES : DRAIN_CYCLES;
   localparam int unsigned MAX_CYC = (MAX_AB > SAVE_CYCLES) ? MAX_AB : SAVE_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

   localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(BOOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] SAVE_LAST  = CNT_W'(SAVE_CYCLES - 1);

   typedef enum logic [2:0] {
      BOOT  = 3'd0,
      RUN   = 3'd1,
      DRAIN = 3'd2,
      SAVE  = 3'd3,
      JUMP  = 3'd4
   } state_t;

   state_t           cur_state, nxt_state;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             irq_d, irq_pend;
   logic             irq_edge, take_irq;

   assign irq_edge = irq & ~irq_d;
   assign state    = cur_state;

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state <= BOOT;
         cnt       <= '0;
         irq_d     <= 1'b0;
         irq_pend  <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         cnt       <= cnt_nxt;
         irq_d     <= irq;
         // An edge coinciding with RUN->DRAIN is the one being serviced.
         if (take_irq)
            irq_pend <= 1'b0;
         else if (irq_edge && cur_state != BOOT)
            irq_pend <= 1'b1;
      end
   end

   always_comb begin
      nxt_state   = cur_state;
      cnt_nxt     = cnt;
      take_irq    = 1'b0;
      pc_en       = 1'b0;
      pc_sel      = 2'b00;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      int_push    = 1'b0;
      busy        = 1'b1;

      case (cur_state)
         BOOT: begin
            pc_sel      = 2'b10;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            if (cnt == BOOT_LAST) begin
               pc_en     = 1'b1;
               nxt_state = RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         RUN: begin
            busy  = 1'b0;
            pc_en = 1'b1;
            if (hz_stall) begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_en     = 1'b0;
               exmem_flush = 1'b1;
            end else if (branch_taken) begin
               pc_sel     = 2'b01;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (irq_pend) begin
               pc_en      = 1'b0;
               ifid_flush = 1'b1;
               nxt_state  = DRAIN;
               cnt_nxt    = '0;
               take_irq   = 1'b1;
            end
         end
         DRAIN: begin
            if (hz_stall) begin
               ifid_en     = 1'b0;
               idex_en     = 1'b0;
               exmem_flush = 1'b1;
            end else begin
               ifid_flush = 1'b1;
               idex_flush = (cnt != '0);
               // Redirect so the PC pushed later is the branch target.
               if (branch_taken) begin
                  pc_en  = 1'b1;
                  pc_sel = 2'b01;
               end
               if (cnt == DRAIN_LAST) begin
                  nxt_state = SAVE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         SAVE: begin
            int_push   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (cnt == SAVE_LAST) begin
               nxt_state = JUMP;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         JUMP: begin
            pc_en      = 1'b1;
            pc_sel     = 2'b11;
            ifid_flush = 1'b1;
            nxt_state  = RUN;
            cnt_nxt    = '0;
         end
         default: begin
            nxt_state = BOOT;
            cnt_nxt   = '0;
         end
      endcase

      if (rst) begin
         pc_en       = 1'b0;
         pc_sel      = 2'b10;
         ifid_en     = 1'b1;
         idex_en     = 1'b1;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         int_push    = 1'b0;
         busy        = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_pipeline_sequencer: scoreboard bench for pipeline_sequencer.        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_pipeline_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       hz_stall = 1'b0;
   logic       branch_taken = 1'b0;
   logic       irq = 1'b0;
   logic       pc_en;
   logic [1:0] pc_sel;
   logic       ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, int_push, busy;
   logic [2:0] state;

   int checks = 0;
   int fails  = 0;
   logic [12:0] sb[$];

   always #5 clk = ~clk;

   pipeline_sequencer dut (
      .clk(clk), .rst(rst), .hz_stall(hz_stall), .branch_taken(branch_taken), .irq(irq),
      .pc_en(pc_en), .pc_sel(pc_sel), .ifid_en(ifid_en), .idex_en(idex_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
      .int_push(int_push), .busy(busy), .state(state)
   );

   wire [12:0] obs = {state, pc_en, pc_sel, ifid_en, idex_en,
                      ifid_flush, idex_flush, exmem_flush, int_push, busy};

   function automatic logic [12:0] ev(input int st, pe, ps, fe, de, f1, f2, f3, ip, bz);
      logic [2:0] s3;
      logic [1:0] p2;
      s3 = st[2:0];
      p2 = ps[1:0];
      return {s3, pe[0], p2, fe[0], de[0], f1[0], f2[0], f3[0], ip[0], bz[0]};
   endfunction

   // Expected output vectors:            st pe ps fe de f1 f2 f3 ip bz
   localparam logic [12:0] BOOT0  = ev(0, 0, 2, 1, 1, 1, 1, 1, 0, 1);
   localparam logic [12:0] BOOT1  = ev(0, 1, 2, 1, 1, 1, 1, 1, 0, 1);
   localparam logic [12:0] RUND   = ev(1, 1, 0, 1, 1, 0, 0, 0, 0, 0);
   localparam logic [12:0] RUNST  = ev(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
   localparam logic [12:0] RUNBR  = ev(1, 1, 1, 1, 1, 1, 1, 0, 0, 0);
   localparam logic [12:0] RUNIRQ = ev(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
   localparam logic [12:0] DR0    = ev(2, 0, 0, 1, 1, 1, 0, 0, 0, 1);
   localparam logic [12:0] DRN    = ev(2, 0, 0, 1, 1, 1, 1, 0, 0, 1);
   localparam logic [12:0] DRST   = ev(2, 0, 0, 0, 0, 0, 0, 1, 0, 1);
   localparam logic [12:0] DRBR   = ev(2, 1, 1, 1, 1, 1, 1, 0, 0, 1);
   localparam logic [12:0] SV     = ev(3, 0, 0, 1, 1, 1, 1, 0, 1, 1);
   localparam logic [12:0] SVRST  = ev(3, 0, 2, 1, 1, 1, 1, 1, 0, 1);
   localparam logic [12:0] JP     = ev(4, 1, 3, 1, 1, 1, 0, 0, 0, 1);

   // Row = {rst, hz_stall, branch_taken, irq, expected outputs for that cycle}
   task automatic test_reset();
      logic [16:0] rows [4] = '{{4'b1000, BOOT0}, {4'b0000, BOOT0}, {4'b0000, BOOT1},
                                {4'b0000, RUND}};
      logic [12:0] exp_v;
      foreach (rows[k]) begin
         @(posedge clk); #1;
         {rst, hz_stall, branch_taken, irq} = rows[k][16:13];
         sb.push_back(rows[k][12:0]);
         @(negedge clk);
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL reset[%0d] got=%b want=%b", k, obs, exp_v);
         end
      end
   endtask

   task automatic test_load_use();
      logic [16:0] rows [3] = '{{4'b0000, RUND}, {4'b0100, RUNST}, {4'b0000, RUND}};
      logic [12:0] exp_v;
      foreach (rows[k]) begin
         @(posedge clk); #1;
         {rst, hz_stall, branch_taken, irq} = rows[k][16:13];
         sb.push_back(rows[k][12:0]);
         @(negedge clk);
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL load_use[%0d] got=%b want=%b", k, obs, exp_v);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [16:0] rows [6] = '{{4'b0110, RUNST}, {4'b0010, RUNBR}, {4'b0000, RUND},
                                {4'b0010, RUNBR}, {4'b0010, RUNBR}, {4'b0100, RUNST}};
      logic [12:0] exp_v;
      foreach (rows[k]) begin
         @(posedge clk); #1;
         {rst, hz_stall, branch_taken, irq} = rows[k][16:13];
         sb.push_back(rows[k][12:0]);
         @(negedge clk);
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL back_to_back[%0d] got=%b want=%b", k, obs, exp_v);
         end
      end
   endtask

   task automatic test_irq_entry();
      logic [16:0] rows [10] = '{{4'b0000, RUND}, {4'b0001, RUND}, {4'b0001, RUNIRQ},
                                 {4'b0001, DR0}, {4'b0001, DRN}, {4'b0001, DRN},
                                 {4'b0001, SV}, {4'b0001, SV}, {4'b0001, JP},
                                 {4'b0001, RUND}};
      logic [12:0] exp_v;
      int busy_cycles = 0;
      foreach (rows[k]) begin
         @(posedge clk); #1;
         {rst, hz_stall, branch_taken, irq} = rows[k][16:13];
         sb.push_back(rows[k][12:0]);
         @(negedge clk);
         if (busy === 1'b1) busy_cycles++;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL irq_entry[%0d] got=%b want=%b", k, obs, exp_v);
         end
      end
      checks++;
      if (busy_cycles !== 6) begin
         fails++;
         $display("FAIL irq_busy_len got=%0d want=6", busy_cycles);
      end
   endtask

   task automatic test_drain_stall();
      logic [16:0] rows [11] = '{{4'b0000, RUND}, {4'b0001, RUND}, {4'b0001, RUNIRQ},
                                 {4'b0001, DR0}, {4'b0101, DRST}, {4'b0001, DRN},
                                 {4'b0001, DRN}, {4'b0001, SV}, {4'b0001, SV},
                                 {4'b0001, JP}, {4'b0000, RUND}};
      logic [12:0] exp_v;
      foreach (rows[k]) begin
         @(posedge clk); #1;
         {rst, hz_stall, branch_taken, irq} = rows[k][16:13];
         sb.push_back(rows[k][12:0]);
         @(negedge clk);
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL drain_stall[%0d] got=%b want=%b", k, obs, exp_v);
         end
      end
   endtask

   task automatic test_drain_branch();
      logic [16:0] rows [10] = '{{4'b0000, RUND}, {4'b0001, RUND}, {4'b0001, RUNIRQ},
                                 {4'b0001, DR0}, {4'b0011, DRBR}, {4'b0001, DRN},
                                 {4'b0001, SV}, {4'b0001, SV}, {4'b0001, JP},
                                 {4'b0000, RUND}};
      logic [12:0] exp_v;
      foreach (rows[k]) begin
         @(posedge clk); #1;
         {rst, hz_stall, branch_taken, irq} = rows[k][16:13];
         sb.push_back(rows[k][12:0]);
         @(negedge clk);
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL drain_branch[%0d] got=%b want=%b", k, obs, exp_v);
         end
      end
   endtask

   task automatic test_irq_deferred();
      logic [16:0] rows [12] = '{{4'b0000, RUND}, {4'b0001, RUND}, {4'b0101, RUNST},
                                 {4'b0011, RUNBR}, {4'b0001, RUNIRQ}, {4'b0001, DR0},
                                 {4'b0001, DRN}, {4'b0001, DRN}, {4'b0001, SV},
                                 {4'b0001, SV}, {4'b0001, JP}, {4'b0000, RUND}};
      logic [12:0] exp_v;
      foreach (rows[k]) begin
         @(posedge clk); #1;
         {rst, hz_stall, branch_taken, irq} = rows[k][16:13];
         sb.push_back(rows[k][12:0]);
         @(negedge clk);
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL irq_deferred[%0d] got=%b want=%b", k, obs, exp_v);
         end
      end
   endtask

   task automatic test_nested_irq();
      logic [16:0] rows [17] = '{{4'b0000, RUND}, {4'b0001, RUND}, {4'b0001, RUNIRQ},
                                 {4'b0001, DR0}, {4'b0001, DRN}, {4'b0001, DRN},
                                 {4'b0000, SV}, {4'b0001, SV}, {4'b0001, JP},
                                 {4'b0001, RUNIRQ}, {4'b0001, DR0}, {4'b0001, DRN},
                                 {4'b0001, DRN}, {4'b0001, SV}, {4'b0101, SV},
                                 {4'b0001, JP}, {4'b0001, RUND}};
      logic [12:0] exp_v;
      foreach (rows[k]) begin
         @(posedge clk); #1;
         {rst, hz_stall, branch_taken, irq} = rows[k][16:13];
         sb.push_back(rows[k][12:0]);
         @(negedge clk);
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL nested_irq[%0d] got=%b want=%b", k, obs, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid_save();
      logic [16:0] rows [11] = '{{4'b0000, RUND}, {4'b0001, RUND}, {4'b0001, RUNIRQ},
                                 {4'b0001, DR0}, {4'b0000, DRN}, {4'b0001, DRN},
                                 {4'b1001, SVRST}, {4'b0001, BOOT0}, {4'b0001, BOOT1},
                                 {4'b0001, RUND}, {4'b0001, RUND}};
      logic [12:0] exp_v;
      foreach (rows[k]) begin
         @(posedge clk); #1;
         {rst, hz_stall, branch_taken, irq} = rows[k][16:13];
         sb.push_back(rows[k][12:0]);
         @(negedge clk);
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL reset_mid_save[%0d] got=%b want=%b", k, obs, exp_v);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_load_use();
      test_back_to_back();
      test_irq_entry();
      test_drain_stall();
      test_drain_branch();
      test_irq_deferred();
      test_nested_irq();
      test_reset_mid_save();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
